cprv_mem_stage: RTL and testbench

- Pipeline stage directly upstream of the writeback stage in cprv64g.
- Takes execute-stage results, performs RV64 loads and stores over a single-outstanding request/grant/rvalid data bus, and produces load data (rdata) plus pass-through fields for writeback.
- Non-memory ops pass straight through with one cycle of latency.
- Holds one instruction at a time.

---
 rtl/cprv_pkg.sv | 42 ++++
 rtl/cprv_mem_stage_if.sv | 39 +++
 rtl/cprv_lsu_align.sv | 50 +++++
 rtl/cprv_mem_stage.sv | 139 +++++++++++++
 tb/tb_cprv_mem_stage.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cprv_pkg.sv
// cprv64g shared definitions: opcodes, access sizes,
// widths and the memory-stage state encoding.
package cprv_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int WORD_WIDTH = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_OUT
  } mem_state_e;

  function automatic logic [7:0] size_be(
    input logic [1:0] sz
  );
    logic [7:0] be;
    be = 8'h00;
    unique case (sz)
      SZ_B: be = 8'h01;
      SZ_H: be = 8'h03;
      SZ_W: be = 8'h0F;
      SZ_D: be = 8'hFF;
      default: be = 8'h00;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/cprv_mem_stage_if.sv
// Single-outstanding req/gnt/rvalid data bus between
// the memory stage (master) and the data memory (slave).
interface cprv_mem_stage_if #(
  parameter int AW = 64,
  parameter int DW = 64
);

  logic          mem_req_o;
  logic          mem_gnt_i;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [7:0]    mem_be_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_be_o,
    output mem_wdata_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_be_o,
    input  mem_wdata_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );

endinterface

// File: rtl/cprv_lsu_align.sv
// Byte-lane steering for RV64 loads/stores: byte
// enables, store shift, load shift/extend, misalign.
module cprv_lsu_align
  import cprv_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  logic [2:0]    off,
  input  logic [1:0]    size,
  input  logic          sext,
  input  logic [DW-1:0] st_data,
  input  logic [DW-1:0] ld_data,
  output logic [7:0]    be,
  output logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          misalign
);

  logic [DW-1:0] sh;

  always_comb begin
    be       = 8'(size_be(size) << off);
    wdata    = st_data << {off, 3'b000};
    sh       = ld_data >> {off, 3'b000};
    misalign = 1'b0;
    rdata    = '0;
    unique case (size)
      SZ_B: begin
        rdata = sext ? DW'($signed(sh[7:0]))
                     : DW'(sh[7:0]);
      end
      SZ_H: begin
        misalign = off[0];
        rdata = sext ? DW'($signed(sh[15:0]))
                     : DW'(sh[15:0]);
      end
      SZ_W: begin
        misalign = |off[1:0];
        rdata = sext ? DW'($signed(sh[31:0]))
                     : DW'(sh[31:0]);
      end
      SZ_D: begin
        misalign = |off;
        rdata = sh;
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/cprv_mem_stage.sv
// cprv64g memory stage: one instruction in flight,
// loads/stores over a single-outstanding data bus.
module cprv_mem_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_mem_i,
  output logic                  ready_mem_o,
  input  logic [6:0]            opcode_mem_i,
  input  logic [2:0]            funct3_mem_i,
  input  logic [4:0]            rd_addr_mem_i,
  input  logic                  rd_en_mem_i,
  input  logic [DATA_WIDTH-1:0] alu_out_mem_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_mem_i,
  output logic                  valid_wb_o,
  input  logic                  ready_wb_i,
  output logic [6:0]            opcode_wb_o,
  output logic [2:0]            funct3_wb_o,
  output logic [4:0]            rd_addr_wb_o,
  output logic                  rd_en_wb_o,
  output logic [DATA_WIDTH-1:0] alu_out_wb_o,
  output logic [DATA_WIDTH-1:0] rdata_wb_o,
  output logic                  misalign_wb_o,
  cprv_mem_stage_if.master      mem
);

  import cprv_pkg::*;

  mem_state_e state;

  logic                  idle;
  logic                  is_ld_i;
  logic                  is_st_i;
  logic                  is_mem_i;
  logic [2:0]            a_off;
  logic [1:0]            a_sz;
  logic                  a_sext;
  logic [7:0]            a_be;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  a_mis;

  assign idle        = (state == ST_IDLE);
  assign ready_mem_o = idle;
  assign is_ld_i     = (opcode_mem_i == OPC_LOAD);
  assign is_st_i     = (opcode_mem_i == OPC_STORE);
  assign is_mem_i    = is_ld_i | is_st_i;

  // IDLE steers from the incoming op, later from the latched one
  always_comb begin
    a_off  = idle ? alu_out_mem_i[2:0] : alu_out_wb_o[2:0];
    a_sz   = idle ? funct3_mem_i[1:0]  : funct3_wb_o[1:0];
    a_sext = idle ? ~funct3_mem_i[2]   : ~funct3_wb_o[2];
  end

  cprv_lsu_align #(
    .DW (DATA_WIDTH)
  ) u_align (
    .off      (a_off),
    .size     (a_sz),
    .sext     (a_sext),
    .st_data  (rs2_data_mem_i),
    .ld_data  (mem.mem_rdata_i),
    .be       (a_be),
    .wdata    (a_wdata),
    .rdata    (a_rdata),
    .misalign (a_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      valid_wb_o      <= 1'b0;
      opcode_wb_o     <= '0;
      funct3_wb_o     <= '0;
      rd_addr_wb_o    <= '0;
      rd_en_wb_o      <= 1'b0;
      alu_out_wb_o    <= '0;
      rdata_wb_o      <= '0;
      misalign_wb_o   <= 1'b0;
      mem.mem_req_o   <= 1'b0;
      mem.mem_we_o    <= 1'b0;
      mem.mem_addr_o  <= '0;
      mem.mem_be_o    <= '0;
      mem.mem_wdata_o <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (valid_mem_i) begin
            opcode_wb_o   <= opcode_mem_i;
            funct3_wb_o   <= funct3_mem_i;
            rd_addr_wb_o  <= rd_addr_mem_i;
            alu_out_wb_o  <= alu_out_mem_i;
            rdata_wb_o    <= '0;
            rd_en_wb_o    <= rd_en_mem_i & ~is_st_i
                             & ~(is_mem_i & a_mis);
            misalign_wb_o <= is_mem_i & a_mis;
            if (is_mem_i && !a_mis) begin
              mem.mem_req_o   <= 1'b1;
              mem.mem_we_o    <= is_st_i;
              mem.mem_addr_o  <= ADDR_WIDTH'(
                {alu_out_mem_i[DATA_WIDTH-1:3], 3'b000});
              mem.mem_be_o    <= a_be;
              mem.mem_wdata_o <= is_st_i ? a_wdata : '0;
              state           <= ST_REQ;
            end else begin
              valid_wb_o <= 1'b1;
              state      <= ST_OUT;
            end
          end
        end
        ST_REQ: begin
          if (mem.mem_gnt_i) begin
            mem.mem_req_o <= 1'b0;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem.mem_rvalid_i) begin
            if (opcode_wb_o == OPC_LOAD)
              rdata_wb_o <= a_rdata;
            valid_wb_o <= 1'b1;
            state      <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (ready_wb_i) begin
            valid_wb_o <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cprv_mem_stage.sv
// Directed + random bench for cprv_mem_stage with a
// byte-lane reference model and a timed bus responder.
module tb_cprv_mem_stage;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_mem_i;
  logic        ready_mem_o;
  logic [6:0]  opcode_mem_i;
  logic [2:0]  funct3_mem_i;
  logic [4:0]  rd_addr_mem_i;
  logic        rd_en_mem_i;
  logic [63:0] alu_out_mem_i;
  logic [63:0] rs2_data_mem_i;
  logic        valid_wb_o;
  logic        ready_wb_i;
  logic [6:0]  opcode_wb_o;
  logic [2:0]  funct3_wb_o;
  logic [4:0]  rd_addr_wb_o;
  logic        rd_en_wb_o;
  logic [63:0] alu_out_wb_o;
  logic [63:0] rdata_wb_o;
  logic        misalign_wb_o;

  int n_tests = 0;
  int n_fail  = 0;

  cprv_mem_stage_if bus ();

  cprv_mem_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_mem_i    (valid_mem_i),
    .ready_mem_o    (ready_mem_o),
    .opcode_mem_i   (opcode_mem_i),
    .funct3_mem_i   (funct3_mem_i),
    .rd_addr_mem_i  (rd_addr_mem_i),
    .rd_en_mem_i    (rd_en_mem_i),
    .alu_out_mem_i  (alu_out_mem_i),
    .rs2_data_mem_i (rs2_data_mem_i),
    .valid_wb_o     (valid_wb_o),
    .ready_wb_i     (ready_wb_i),
    .opcode_wb_o    (opcode_wb_o),
    .funct3_wb_o    (funct3_wb_o),
    .rd_addr_wb_o   (rd_addr_wb_o),
    .rd_en_wb_o     (rd_en_wb_o),
    .alu_out_wb_o   (alu_out_wb_o),
    .rdata_wb_o     (rdata_wb_o),
    .misalign_wb_o  (misalign_wb_o),
    .mem            (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; bus timing set by gd/rvd, wb stall by wd
  task automatic run_op(input logic [6:0]  op,
                        input logic [2:0]  f3,
                        input logic [63:0] addr,
                        input logic [63:0] rs2,
                        input logic [63:0] rmem,
                        input logic [4:0]  rd,
                        input logic        rde,
                        input int          gd,
                        input int          rvd,
                        input int          wd);
    logic        is_mem, is_ld, is_st, mis;
    int          nb, lo;
    logic [15:0] be16;
    logic [63:0] e_be, e_wd, e_rd, v, mask, hold_rd;
    is_ld  = (op == LOAD);
    is_st  = (op == STORE);
    is_mem = is_ld || is_st;
    nb     = 1 << f3[1:0];
    lo     = int'(addr[2:0]);
    mis    = is_mem && ((lo % nb) != 0);
    be16   = ((16'd1 << nb) - 16'd1) << lo;
    e_be   = 64'(be16[7:0]);
    e_wd   = rs2 << (8 * lo);
    e_rd   = 64'd0;
    if (is_ld && !mis) begin
      v = rmem >> (8 * lo);
      if (nb == 8) e_rd = v;
      else begin
        mask = (64'd1 << (8 * nb)) - 64'd1;
        e_rd = v & mask;
        if (!f3[2] && e_rd[8 * nb - 1]) e_rd = e_rd | ~mask;
      end
    end

    chk("ready_before", 64'(ready_mem_o), 64'd1);
    opcode_mem_i   = op;
    funct3_mem_i   = f3;
    alu_out_mem_i  = addr;
    rs2_data_mem_i = rs2;
    rd_addr_mem_i  = rd;
    rd_en_mem_i    = rde;
    valid_mem_i    = 1'b1;
    ready_wb_i     = 1'b0;
    tick();
    valid_mem_i    = 1'b0;
    alu_out_mem_i  = {$urandom, $urandom};
    rs2_data_mem_i = {$urandom, $urandom};
    opcode_mem_i   = 7'($urandom);
    funct3_mem_i   = 3'($urandom);

    if (is_mem && !mis) begin
      chk("req_up", 64'(bus.mem_req_o), 64'd1);
      chk("addr", bus.mem_addr_o, addr & ~64'd7);
      chk("be", 64'(bus.mem_be_o), e_be);
      chk("we", 64'(bus.mem_we_o), 64'(is_st));
      if (is_st) chk("wdata", bus.mem_wdata_o, e_wd);
      chk("ready_busy", 64'(ready_mem_o), 64'd0);
      for (int i = 0; i < gd; i++) begin
        bus.mem_rvalid_i = 1'b1;
        tick();
        bus.mem_rvalid_i = 1'b0;
        chk("req_hold", 64'(bus.mem_req_o), 64'd1);
        chk("addr_hold", bus.mem_addr_o, addr & ~64'd7);
        chk("be_hold", 64'(bus.mem_be_o), e_be);
      end
      bus.mem_gnt_i = 1'b1;
      tick();
      bus.mem_gnt_i = 1'b0;
      chk("req_drop", 64'(bus.mem_req_o), 64'd0);
      for (int i = 0; i < rvd; i++) begin
        tick();
        chk("wait_valid", 64'(valid_wb_o), 64'd0);
      end
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = rmem;
      tick();
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = {$urandom, $urandom};
    end else begin
      chk("no_req", 64'(bus.mem_req_o), 64'd0);
    end

    chk("valid_wb", 64'(valid_wb_o), 64'd1);
    chk("opcode_wb", 64'(opcode_wb_o), 64'(op));
    chk("funct3_wb", 64'(funct3_wb_o), 64'(f3));
    chk("rd_addr_wb", 64'(rd_addr_wb_o), 64'(rd));
    chk("rd_en_wb", 64'(rd_en_wb_o),
        64'(rde && !is_st && !mis));
    chk("alu_out_wb", alu_out_wb_o, addr);
    chk("rdata_wb", rdata_wb_o, e_rd);
    chk("misalign_wb", 64'(misalign_wb_o), 64'(mis));
    hold_rd = e_rd;
    for (int i = 0; i < wd; i++) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = {$urandom, $urandom};
      tick();
      bus.mem_rvalid_i = 1'b0;
      chk("stall_valid", 64'(valid_wb_o), 64'd1);
      chk("stall_ready", 64'(ready_mem_o), 64'd0);
      chk("stall_rdata", rdata_wb_o, hold_rd);
      chk("stall_alu", alu_out_wb_o, addr);
    end
    ready_wb_i = 1'b1;
    tick();
    ready_wb_i = 1'b0;
    chk("valid_drop", 64'(valid_wb_o), 64'd0);
    chk("ready_after", 64'(ready_mem_o), 64'd1);
  endtask

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [63:0] a;
    int          k;

    rst_n            = 1'b0;
    valid_mem_i      = 1'b0;
    ready_wb_i       = 1'b0;
    opcode_mem_i     = '0;
    funct3_mem_i     = '0;
    rd_addr_mem_i    = '0;
    rd_en_mem_i      = 1'b0;
    alu_out_mem_i    = '0;
    rs2_data_mem_i   = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    #12;
    chk("rst_ready", 64'(ready_mem_o), 64'd1);
    chk("rst_valid", 64'(valid_wb_o), 64'd0);
    chk("rst_req", 64'(bus.mem_req_o), 64'd0);
    chk("rst_be", 64'(bus.mem_be_o), 64'd0);
    chk("rst_alu", alu_out_wb_o, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op(OP, 3'd0, 64'h1234, 64'd0, 64'd0,
           5'd5, 1'b1, 0, 0, 0);
    run_op(LOAD, 3'b000, 64'h1003, 64'd0,
           64'h0000_0000_8000_0000, 5'd6, 1'b1, 0, 0, 0);
    run_op(LOAD, 3'b100, 64'h1003, 64'd0,
           64'h0000_0000_8000_0000, 5'd6, 1'b1, 0, 0, 0);
    run_op(STORE, 3'b001, 64'h2006, 64'hABCD, 64'd0,
           5'd7, 1'b1, 0, 0, 0);
    run_op(LOAD, 3'b010, 64'h3002, 64'd0, 64'd0,
           5'd8, 1'b1, 0, 0, 0);
    run_op(LOAD, 3'b011, 64'h5008, 64'd0,
           64'hDEAD_BEEF_0123_4567, 5'd9, 1'b1, 3, 2, 4);
    run_op(LOAD, 3'b111, 64'h5010, 64'd0,
           64'h8765_4321_0FED_CBA9, 5'd10, 1'b1, 1, 0, 1);

    // reset while a load is waiting for rvalid
    opcode_mem_i  = LOAD;
    funct3_mem_i  = 3'b011;
    alu_out_mem_i = 64'h4000;
    rd_addr_mem_i = 5'd3;
    rd_en_mem_i   = 1'b1;
    valid_mem_i   = 1'b1;
    tick();
    valid_mem_i   = 1'b0;
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
    chk("wait_req", 64'(bus.mem_req_o), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(ready_mem_o), 64'd1);
    chk("arst_valid", 64'(valid_wb_o), 64'd0);
    chk("arst_be", 64'(bus.mem_be_o), 64'd0);
    chk("arst_addr", bus.mem_addr_o, 64'd0);
    chk("arst_alu", alu_out_wb_o, 64'd0);
    chk("arst_rden", 64'(rd_en_wb_o), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(LOAD, 3'b011, 64'h4000, 64'd0,
           64'h0102_0304_0506_0708, 5'd3, 1'b1, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(0, 3));
      op = (k == 0) ? LOAD : (k == 1) ? STORE :
           (k == 2) ? OP : OP_IMM;
      f3 = 3'($urandom);
      if (op == STORE) f3[2] = 1'b0;
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0)
        a = a & ~((64'd1 << f3[1:0]) - 64'd1);
      run_op(op, f3, a, {$urandom, $urandom},
             {$urandom, $urandom}, 5'($urandom),
             1'($urandom), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
